// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared types and codes for the execute-stage divider.
// Holds FSM state encoding and the ALU control codes that select DIV/DIVU.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } divState_e;

    localparam logic [3:0] ALU_DIV  = 4'b1010;
    localparam logic [3:0] ALU_DIVU = 4'b1011;

    function automatic logic isDivOp(input logic [3:0] aluControl);
        return (aluControl == ALU_DIV) || (aluControl == ALU_DIVU);
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: request/result bundle between execute stage and divider.
// master = pipeline side (drives request), slave = divider (drives result).
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             startE;
    logic             signedE;
    logic             annulE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             stall_divE;
    logic             readyE;
    logic [WIDTH-1:0] hiE;
    logic [WIDTH-1:0] loE;

    modport master (
        output startE, signedE, annulE, srcaE, srcbE,
        input  stall_divE, readyE, hiE, loE
    );

    modport slave (
        input  startE, signedE, annulE, srcaE, srcbE,
        output stall_divE, readyE, hiE, loE
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider, one quotient bit per cycle.
// Ports: clk, rst (sync, active-high), bus (div_unit_if.slave: request in, HI/LO + stall/ready out).
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic clk,
    input logic rst,
    div_unit_if.slave bus
);

    divState_e state, stateNext;

    logic [WIDTH-1:0] rem, quot, divisor, dividendRaw;
    logic             negQ, negR, divZero;
    logic [CNT_W-1:0] count;

    logic [WIDTH:0]   shifted, diff;
    logic             fits, lastIter;
    logic [WIDTH-1:0] remNext, quotNext, hiFinal, loFinal;
    logic             aNeg, bNeg;
    logic [WIDTH-1:0] aMag, bMag;

    function automatic logic [WIDTH-1:0] negIf(input logic en, input logic [WIDTH-1:0] v);
        return en ? (~v + 1'b1) : v;
    endfunction

    assign aNeg = bus.signedE & bus.srcaE[WIDTH-1];
    assign bNeg = bus.signedE & bus.srcbE[WIDTH-1];
    assign aMag = negIf(aNeg, bus.srcaE);
    assign bMag = negIf(bNeg, bus.srcbE);

    assign lastIter = (count == CNT_W'(WIDTH-1));

    // A shifted value with its top bit set always exceeds the divisor;
    // otherwise the top bit of the difference is the borrow.
    assign shifted  = {rem, quot[WIDTH-1]};
    assign diff     = shifted - {1'b0, divisor};
    assign fits     = shifted[WIDTH] | ~diff[WIDTH];
    assign remNext  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quotNext = {quot[WIDTH-2:0], fits};

    assign hiFinal = divZero ? dividendRaw : negIf(negR, remNext);
    assign loFinal = divZero ? '1 : negIf(negQ, quotNext);

    always_ff @(posedge clk) begin
        if (rst) state <= DIV_IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext      = state;
        bus.stall_divE = 1'b0;
        bus.readyE     = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (bus.startE && !bus.annulE) begin
                    stateNext      = DIV_CALC;
                    bus.stall_divE = 1'b1;
                end
            end
            DIV_CALC: begin
                bus.stall_divE = 1'b1;
                if (bus.annulE)    stateNext = DIV_IDLE;
                else if (lastIter) stateNext = DIV_DONE;
            end
            DIV_DONE: begin
                // A startE still high here belongs to the finished instruction.
                stateNext  = DIV_IDLE;
                bus.readyE = !bus.annulE;
            end
            default: stateNext = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem         <= '0;
            quot        <= '0;
            divisor     <= '0;
            dividendRaw <= '0;
            negQ        <= 1'b0;
            negR        <= 1'b0;
            divZero     <= 1'b0;
            count       <= '0;
            bus.hiE     <= '0;
            bus.loE     <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (bus.startE && !bus.annulE) begin
                        rem         <= '0;
                        quot        <= aMag;
                        divisor     <= bMag;
                        dividendRaw <= bus.srcaE;
                        negQ        <= aNeg ^ bNeg;
                        negR        <= aNeg;
                        divZero     <= (bus.srcbE == '0);
                        count       <= '0;
                    end
                end
                DIV_CALC: begin
                    if (!bus.annulE) begin
                        rem   <= remNext;
                        quot  <= quotNext;
                        count <= count + 1'b1;
                        // Results land on the edge into DONE so they are visible with readyE.
                        if (lastIter) begin
                            bus.hiE <= hiFinal;
                            bus.loE <= loFinal;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit with a plain-arithmetic model.
// Driver issues divides and aborts; monitor pops expectations on readyE.
module tb_div_unit;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] expLoQ[$];
    logic [W-1:0] expHiQ[$];
    logic [W-1:0] lastLo = '0;
    logic [W-1:0] lastHi = '0;
    int stallRun = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input bit sgn, output logic [W-1:0] lo,
                                  output logic [W-1:0] hi);
        if (b == '0) begin
            lo = '1;
            hi = a;
        end else if (sgn) begin
            longint sa;
            longint sb;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lo = W'(sa / sb);
            hi = W'(sa % sb);
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    always @(negedge clk) begin
        if (bus.stall_divE === 1'b1) begin
            stallRun++;
        end else begin
            if (bus.readyE === 1'b1) begin
                if (expLoQ.size() == 0) begin
                    chk("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    logic [W-1:0] eLo, eHi;
                    eLo = expLoQ.pop_front();
                    eHi = expHiQ.pop_front();
                    chk("loE", bus.loE, eLo);
                    chk("hiE", bus.hiE, eHi);
                    chk("stall_cycles", W'(stallRun), W'(W + 1));
                    lastLo = eLo;
                    lastHi = eHi;
                end
            end
            stallRun = 0;
        end
    end

    task automatic doDiv(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
        logic [W-1:0] lo, hi;
        bit seen;
        model(a, b, sgn, lo, hi);
        expLoQ.push_back(lo);
        expHiQ.push_back(hi);
        @(posedge clk);
        #2;
        bus.srcaE   = a;
        bus.srcbE   = b;
        bus.signedE = sgn;
        bus.startE  = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (bus.readyE === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            chk("ready_timeout", 32'd0, 32'd1);
            void'(expLoQ.pop_back());
            void'(expHiQ.pop_back());
        end
        @(posedge clk);
        #2;
        bus.startE = 1'b0;
    endtask

    task automatic doAbort(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int calcCycles, input bit useRst);
        @(posedge clk);
        #2;
        bus.srcaE   = a;
        bus.srcbE   = b;
        bus.signedE = 1'b0;
        bus.startE  = 1'b1;
        repeat (calcCycles + 1) @(posedge clk);
        #2;
        bus.startE = 1'b0;
        if (useRst) rst = 1'b1;
        else        bus.annulE = 1'b1;
        @(posedge clk);
        #2;
        rst        = 1'b0;
        bus.annulE = 1'b0;
        if (useRst) begin
            lastLo = '0;
            lastHi = '0;
        end
        @(negedge clk);
        chk(useRst ? "rst_stall" : "annul_stall", W'(bus.stall_divE), '0);
        chk(useRst ? "rst_ready" : "annul_ready", W'(bus.readyE), '0);
        chk(useRst ? "rst_loE" : "annul_loE", bus.loE, lastLo);
        chk(useRst ? "rst_hiE" : "annul_hiE", bus.hiE, lastHi);
    endtask

    initial begin
        bus.startE  = 1'b0;
        bus.signedE = 1'b0;
        bus.annulE  = 1'b0;
        bus.srcaE   = '0;
        bus.srcbE   = '0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_stall", W'(bus.stall_divE), '0);
        chk("reset_ready", W'(bus.readyE), '0);
        chk("reset_loE", bus.loE, '0);
        chk("reset_hiE", bus.hiE, '0);

        doDiv(32'd100, 32'd7, 1'b0);
        doDiv(32'hFFFFFF9C, 32'd7, 1'b1);
        doDiv(32'd100, 32'hFFFFFFF9, 1'b1);
        doDiv(32'h12345678, 32'd0, 1'b0);
        doDiv(32'h80000000, 32'hFFFFFFFF, 1'b1);
        doDiv(32'hFFFFFFFF, 32'd1, 1'b0);
        doDiv(32'hFFFFFFF9, 32'd0, 1'b1);

        doAbort(32'd1000, 32'd3, 10, 1'b0);
        doDiv(32'd9, 32'd2, 1'b0);

        doAbort(32'd777, 32'd5, 20, 1'b1);
        doDiv(32'd50, 32'd5, 1'b0);
        doDiv(32'd7, 32'd3, 1'b0);

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] a, b;
            int r;
            r = int'($urandom_range(0, 9));
            a = $urandom;
            if (r < 2)      b = '0;
            else if (r < 5) b = W'($urandom_range(1, 15));
            else if (r < 6) b = 32'hFFFFFFFF;
            else            b = $urandom;
            doDiv(a, b, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", W'(expLoQ.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
